// File: rtl/vga_pattern_gen.sv
// Raster timing and synthetic RGB888 test-pattern source for the equalization path.
// Counters are decoded combinationally, then every output is registered together.
module vga_pattern_gen #(
  parameter int unsigned H_DISP   = 1024,
  parameter int unsigned H_FRONT  = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BACK   = 160,
  parameter int unsigned V_DISP   = 768,
  parameter int unsigned V_FRONT  = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BACK   = 29,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  output logic        img_hsync,
  output logic        img_vsync,
  output logic        img_de,
  output logic [23:0] img_data,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BAR_W   = H_DISP / 8;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    mode_q;
  logic [15:0]   frame_q;
  logic          h_last, v_last;

  logic [31:0]   x, y;
  logic          de_d, hs_d, vs_d;
  logic [23:0]   pat, data_d;
  logic [2:0]    bar;
  logic [7:0]    g;

  assign h_last = (h_q == HW'(H_TOTAL - 1));
  assign v_last = (v_q == VW'(V_TOTAL - 1));

  always_comb begin
    h_d = h_last ? '0 : h_q + HW'(1);
    v_d = v_q;
    if (h_last) begin
      v_d = v_last ? '0 : v_q + VW'(1);
    end
  end

  always_comb begin
    x    = 32'(h_q);
    y    = 32'(v_q);
    de_d = (x < H_DISP) && (y < V_DISP);
    hs_d = ((x >= H_DISP + H_FRONT) && (x < H_DISP + H_FRONT + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    vs_d = ((y >= V_DISP + V_FRONT) && (y < V_DISP + V_FRONT + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    bar  = 3'(x / BAR_W);
    g    = 8'h00;
    pat  = 24'h000000;
    unique case (mode_q)
      2'd0: begin
        unique case (bar)
          3'd0: pat = 24'hFFFFFF;
          3'd1: pat = 24'hFFFF00;
          3'd2: pat = 24'h00FFFF;
          3'd3: pat = 24'h00FF00;
          3'd4: pat = 24'hFF00FF;
          3'd5: pat = 24'hFF0000;
          3'd6: pat = 24'h0000FF;
          3'd7: pat = 24'h000000;
        endcase
      end
      2'd1: begin
        g   = 8'd96 + {2'b00, x[5:0]};
        pat = {g, g, g};
      end
      2'd2: pat = (x[6] ^ y[6]) ? 24'hFFFFFF : 24'h000000;
      2'd3: begin
        // Gradient scrolls by one grey level per completed frame.
        g   = y[7:0] + frame_q[7:0];
        pat = {g, g, g};
      end
    endcase
    data_d = de_d ? pat : 24'h000000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      mode_q    <= 2'd0;
      frame_q   <= 16'd0;
      img_de    <= 1'b0;
      img_data  <= 24'h000000;
      img_hsync <= ~SYNC_POL;
      img_vsync <= ~SYNC_POL;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      img_de    <= de_d;
      img_data  <= data_d;
      img_hsync <= hs_d;
      img_vsync <= vs_d;
      // Pattern select only changes between frames so no frame is mixed.
      if (h_last && v_last) begin
        mode_q  <= mode;
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a small raster (24 x 8 clocks per frame).
// A frame-level reference model predicts every registered output on every clock.
module tb_vga_pattern_gen;

  localparam int HD = 16, HF = 2, HS = 3, HB = 3;
  localparam int VD = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        img_hsync, img_vsync, img_de;
  logic [23:0] img_data;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: raster position about to be shown, frame pattern and frame count.
  int          mpos;
  logic [1:0]  mmode;
  logic [15:0] mfcnt;
  logic [42:0] exp_v, obs_v;
  logic [23:0] bar_tbl [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_pattern_gen #(
    .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .img_hsync(img_hsync),
    .img_vsync(img_vsync),
    .img_de   (img_de),
    .img_data (img_data),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pixel(int x, int y, logic [1:0] m, logic [15:0] f);
    int g;
    if (x >= HD || y >= VD) return 24'h0;
    case (m)
      2'd0: return bar_tbl[x / (HD / 8)];
      2'd1: begin g = 96 + (x % 64); return {g[7:0], g[7:0], g[7:0]}; end
      2'd2: return ((((x / 64) % 2) ^ ((y / 64) % 2)) != 0) ? 24'hFFFFFF : 24'h0;
      default: begin g = (y + int'(f)) % 256; return {g[7:0], g[7:0], g[7:0]}; end
    endcase
  endfunction

  // Predicts {hsync, vsync, de, data, frame_cnt} after this edge and advances the model.
  task automatic model_edge(output logic [42:0] e);
    int x, y;
    logic hs, vs, de;
    logic [23:0] d;
    if (!rst_n) begin
      mpos  = 0;
      mmode = 2'd0;
      mfcnt = 16'd0;
      e     = {1'b1, 1'b1, 1'b0, 24'h0, 16'h0};
    end else begin
      x  = mpos % HT;
      y  = mpos / HT;
      de = (x < HD) && (y < VD);
      hs = !(x >= HD + HF && x < HD + HF + HS);
      vs = !(y >= VD + VF && y < VD + VF + VS);
      d  = pixel(x, y, mmode, mfcnt);
      if (mpos == FT - 1) begin
        mmode = mode;
        mfcnt = mfcnt + 16'd1;
      end
      mpos = (mpos + 1) % FT;
      e    = {hs, vs, de, d, mfcnt};
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_edge(exp_v);
    #1;
    obs_v = {img_hsync, img_vsync, img_de, img_data, frame_cnt};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode  = 2'd2;
    repeat (3) begin
      clk_step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_values got=%h want=%h", obs_v, exp_v);
      end
    end
    mode  = 2'd0;
    rst_n = 1'b1;
  endtask

  task automatic test_bars_line();
    int de_cnt = 0;
    logic [23:0] hs_mask = '0;
    for (int i = 0; i < HT; i++) begin
      clk_step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL bars_line x=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i < HD) begin
        checks++;
        if (img_data !== bar_tbl[i / 2]) begin
          errors++;
          $display("FAIL bars_data x=%0d got=%h want=%h", i, img_data, bar_tbl[i / 2]);
        end
      end
      if (img_de === 1'b1) de_cnt++;
      if (img_hsync === 1'b0) hs_mask[i] = 1'b1;
    end
    checks++;
    if (de_cnt != 16) begin
      errors++;
      $display("FAIL de_per_line got=%0d want=16", de_cnt);
    end
    checks++;
    if (hs_mask !== 24'h1C0000) begin
      errors++;
      $display("FAIL hsync_window got=%h want=1c0000", hs_mask);
    end
  endtask

  task automatic test_vertical();
    int vs_cnt = 0, vs_first = -1, de_lines = 0;
    for (int t = HT; t < FT; t++) begin
      clk_step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL vertical t=%0d got=%h want=%h", t, obs_v, exp_v);
      end
      if (img_vsync === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = t;
      end
      if (img_de === 1'b1 && (t % HT) == 0) de_lines++;
    end
    checks++;
    if (vs_cnt != 48 || vs_first != 5 * HT) begin
      errors++;
      $display("FAIL vsync_window got=%0d@%0d want=48@120", vs_cnt, vs_first);
    end
    checks++;
    if (de_lines != 3) begin
      errors++;
      $display("FAIL de_lines_1to3 got=%0d want=3", de_lines);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL frame_cnt_after_192 got=%0d want=1", frame_cnt);
    end
  endtask

  task automatic test_mode_change();
    logic [7:0] g;
    for (int t = 0; t < 2 * FT; t++) begin
      if (t == 2 * HT) mode = 2'd1;
      if (t == FT + HT) mode = 2'd3;
      clk_step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL mode_change t=%0d got=%h want=%h", t, obs_v, exp_v);
      end
      if (t >= FT && t < FT + HD) begin
        g = 8'(96 + t - FT);
        checks++;
        if (img_data !== {g, g, g}) begin
          errors++;
          $display("FAIL ramp x=%0d got=%h want=%h", t - FT, img_data, {g, g, g});
        end
      end
    end
  endtask

  task automatic test_animated();
    logic [7:0] g;
    for (int f = 0; f < 3; f++) begin
      for (int t = 0; t < FT; t++) begin
        clk_step();
        checks++;
        if (obs_v !== exp_v) begin
          errors++;
          $display("FAIL animated f=%0d t=%0d got=%h want=%h", f, t, obs_v, exp_v);
        end
        if ((t % HT) == 0 && (t / HT) < VD) begin
          g = 8'(t / HT + 3 + f);
          checks++;
          if (img_data !== {g, g, g}) begin
            errors++;
            $display("FAIL anim_pixel f=%0d y=%0d got=%h want=%h", f, t / HT, img_data, {g, g, g});
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 2 * HT + 5; t++) begin
      clk_step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL pre_reset t=%0d got=%h want=%h", t, obs_v, exp_v);
      end
    end
    rst_n = 1'b0;
    clk_step();
    checks++;
    if (obs_v !== {1'b1, 1'b1, 1'b0, 24'h0, 16'h0}) begin
      errors++;
      $display("FAIL mid_reset got=%h want=%h", obs_v, {1'b1, 1'b1, 1'b0, 24'h0, 16'h0});
    end
    rst_n = 1'b1;
    for (int t = 0; t < FT; t++) begin
      clk_step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL post_reset t=%0d got=%h want=%h", t, obs_v, exp_v);
      end
      if (t == 0) begin
        checks++;
        if (img_data !== 24'hFFFFFF || frame_cnt !== 16'd0) begin
          errors++;
          $display("FAIL restart_pixel got=%h/%0d want=ffffff/0", img_data, frame_cnt);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8 * FT; t++) begin
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 1999) != 0);
      clk_step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random t=%0d got=%h want=%h", t, obs_v, exp_v);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frame_wrap();
    int saw_zero = 0;
    mode = 2'd3;
    force dut.frame_q = 16'hFFFE;
    #1;
    release dut.frame_q;
    mfcnt = 16'hFFFE;
    for (int t = 0; t < 3 * FT; t++) begin
      clk_step();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL frame_wrap t=%0d got=%h want=%h", t, obs_v, exp_v);
      end
      if (frame_cnt === 16'h0000) saw_zero++;
    end
    checks++;
    if (saw_zero == 0) begin
      errors++;
      $display("FAIL frame_cnt_rollover got=%0d want=nonzero", saw_zero);
    end
  endtask

  initial begin
    test_reset();
    test_bars_line();
    test_vertical();
    test_mode_change();
    test_animated();
    test_reset_mid();
    test_random();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
